// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle IEEE-754 single-precision add/subtract sequencer
module fp_addsub_seq #(
    parameter int NORM_MAX = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    localparam logic [7:0]  L_NORM_MAX = 8'(NORM_MAX);
    localparam logic [31:0] L_QNAN     = 32'h7FC0_0000;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_a, r_b;
    logic [7:0]  r_exp;
    logic [23:0] r_man_l, r_man_s, r_mag;
    logic        r_sign_l, r_sign_s, r_sign_r;
    logic [7:0]  r_cnt;
    logic [31:0] r_result;
    logic        w_fin;
    logic [31:0] w_fin_val;

    // Unpack and align, evaluated from the captured operands
    logic [7:0]  w_ea, w_eb, w_exp_l, w_exp_s, w_d;
    logic [23:0] w_ma, w_mb, w_man_l, w_man_s_raw, w_man_s_sh;
    logic        w_swap, w_sign_l, w_sign_s;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_special;
    logic [31:0] w_special_res;

    assign w_ea        = r_a[30:23];
    assign w_eb        = r_b[30:23];
    assign w_ma        = (w_ea != 8'd0) ? {1'b1, r_a[22:0]} : 24'd0;
    assign w_mb        = (w_eb != 8'd0) ? {1'b1, r_b[22:0]} : 24'd0;
    assign w_swap      = (w_eb > w_ea);
    assign w_exp_l     = w_swap ? w_eb : w_ea;
    assign w_exp_s     = w_swap ? w_ea : w_eb;
    assign w_man_l     = w_swap ? w_mb : w_ma;
    assign w_man_s_raw = w_swap ? w_ma : w_mb;
    assign w_sign_l    = w_swap ? r_b[31] : r_a[31];
    assign w_sign_s    = w_swap ? r_a[31] : r_b[31];
    assign w_d         = w_exp_l - w_exp_s;
    assign w_man_s_sh  = (w_d >= 8'd25) ? 24'd0 : (w_man_s_raw >> w_d);

    assign w_nan_a   = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_nan_b   = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_inf_a   = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_inf_b   = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b;

    // Special-case result: NaN wins, opposite infinities make NaN, else the infinity
    always_comb begin
        w_special_res = {r_b[31], 8'hFF, 23'd0};
        if (w_nan_a || w_nan_b)
            w_special_res = L_QNAN;
        else if (w_inf_a && w_inf_b && (r_a[31] != r_b[31]))
            w_special_res = L_QNAN;
        else if (w_inf_a)
            w_special_res = {r_a[31], 8'hFF, 23'd0};
    end

    // Signed add: a full 26-bit negation, so a zero mantissa with sign set stays zero
    logic [25:0] w_op_l, w_op_s, w_sum, w_mag;
    assign w_op_l = r_sign_l ? (26'd0 - {2'b00, r_man_l}) : {2'b00, r_man_l};
    assign w_op_s = r_sign_s ? (26'd0 - {2'b00, r_man_s}) : {2'b00, r_man_s};
    assign w_sum  = w_op_l + w_op_s;
    assign w_mag  = w_sum[25] ? (26'd0 - w_sum) : w_sum;

    // Normalisation step: a shift that lands the leading one packs in the same cycle
    logic [23:0] w_shl;
    logic [7:0]  w_exp_m1;
    assign w_shl    = {r_mag[22:0], 1'b0};
    assign w_exp_m1 = r_exp - 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state and the final result value for transitions into DONE
    always_comb begin
        w_state_next = r_state;
        w_fin        = 1'b0;
        w_fin_val    = 32'd0;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_ALIGN;
            S_ALIGN: begin
                if (w_special) begin
                    w_state_next = S_DONE;
                    w_fin        = 1'b1;
                    w_fin_val    = w_special_res;
                end else begin
                    w_state_next = S_ADD;
                end
            end
            S_ADD: begin
                if (w_mag == 26'd0) begin
                    w_state_next = S_DONE;
                    w_fin        = 1'b1;
                end else if (w_mag[24] && (r_exp == 8'd254)) begin
                    w_state_next = S_DONE;
                    w_fin        = 1'b1;
                    w_fin_val    = {w_sum[25], 8'hFF, 23'd0};
                end else begin
                    w_state_next = S_NORM;
                end
            end
            S_NORM: begin
                w_state_next = S_DONE;
                w_fin        = 1'b1;
                if (r_cnt > L_NORM_MAX)
                    w_fin_val = 32'd0;
                else if (r_mag[23])
                    w_fin_val = {r_sign_r, r_exp, r_mag[22:0]};
                else if (w_exp_m1 == 8'd0)
                    w_fin_val = {r_sign_r, 31'd0};
                else if (w_shl[23])
                    w_fin_val = {r_sign_r, w_exp_m1, w_shl[22:0]};
                else begin
                    w_state_next = S_NORM;
                    w_fin        = 1'b0;
                end
            end
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers, updated per state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_exp    <= 8'd0;
            r_man_l  <= 24'd0;
            r_man_s  <= 24'd0;
            r_mag    <= 24'd0;
            r_sign_l <= 1'b0;
            r_sign_s <= 1'b0;
            r_sign_r <= 1'b0;
            r_cnt    <= 8'd0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= {b[31] ^ op, b[30:0]};
                    end
                end
                S_ALIGN: begin
                    r_exp    <= w_exp_l;
                    r_man_l  <= w_man_l;
                    r_man_s  <= w_man_s_sh;
                    r_sign_l <= w_sign_l;
                    r_sign_s <= w_sign_s;
                    r_cnt    <= 8'd0;
                end
                S_ADD: begin
                    r_sign_r <= w_sum[25];
                    r_mag    <= w_mag[24] ? w_mag[24:1] : w_mag[23:0];
                    r_exp    <= w_mag[24] ? (r_exp + 8'd1) : r_exp;
                end
                S_NORM: begin
                    r_mag <= w_shl;
                    r_exp <= w_exp_m1;
                    r_cnt <= r_cnt + 8'd1;
                end
                default: ;
            endcase
            if (w_fin) r_result <= w_fin_val;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - scoreboard bench for fp_addsub_seq
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    fp_addsub_seq #(.NORM_MAX(26)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: on the first cycle of each out_valid, pop and compare value and latency
    initial begin
        logic seen;
        logic [31:0] er;
        int el, ac;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !out_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", result, 32'hxxxxxxxx);
                end else begin
                    er = exp_q.pop_front();
                    el = lat_q.pop_front();
                    ac = acc_q.pop_front();
                    chk("result", result, er);
                    chk("latency", 32'(cyc - ac), 32'(el));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb2, input logic top,
                         input logic [31:0] er, input int el);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("issue_ready", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb2; op = top; in_valid = 1'b1;
        exp_q.push_back(er);
        lat_q.push_back(el);
        acc_q.push_back(cyc);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!(exp_q.size() == 0 && in_ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] va[12], vb[12], vr[12];
    logic        vo[12];
    int          vl[12];

    initial begin
        // a, b, op, expected result, expected accept-to-valid latency
        va[0]  = 32'h3F800000; vb[0]  = 32'h3F800000; vo[0]  = 0; vr[0]  = 32'h40000000; vl[0]  = 4;
        va[1]  = 32'h3FC00000; vb[1]  = 32'h3FA00000; vo[1]  = 1; vr[1]  = 32'h3E800000; vl[1]  = 5;
        va[2]  = 32'h40490FDB; vb[2]  = 32'h40490FDB; vo[2]  = 1; vr[2]  = 32'h00000000; vl[2]  = 3;
        va[3]  = 32'h4B800000; vb[3]  = 32'h3F800000; vo[3]  = 0; vr[3]  = 32'h4B800000; vl[3]  = 4;
        va[4]  = 32'h7F7FFFFF; vb[4]  = 32'h7F7FFFFF; vo[4]  = 0; vr[4]  = 32'h7F800000; vl[4]  = 3;
        va[5]  = 32'h7F800000; vb[5]  = 32'h7F800000; vo[5]  = 1; vr[5]  = 32'h7FC00000; vl[5]  = 2;
        va[6]  = 32'h7FC00001; vb[6]  = 32'h3F800000; vo[6]  = 0; vr[6]  = 32'h7FC00000; vl[6]  = 2;
        va[7]  = 32'h7F800000; vb[7]  = 32'h3F800000; vo[7]  = 0; vr[7]  = 32'h7F800000; vl[7]  = 2;
        va[8]  = 32'h3F800000; vb[8]  = 32'h7F800000; vo[8]  = 1; vr[8]  = 32'hFF800000; vl[8]  = 2;
        va[9]  = 32'h40000000; vb[9]  = 32'hBF800000; vo[9]  = 0; vr[9]  = 32'h3F800000; vl[9]  = 4;
        va[10] = 32'h3F800000; vb[10] = 32'h40000000; vo[10] = 1; vr[10] = 32'hBF800000; vl[10] = 4;
        va[11] = 32'h3F800001; vb[11] = 32'h3F800000; vo[11] = 1; vr[11] = 32'h34000000; vl[11] = 26;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_result",    result,             32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(va[i], vb[i], vo[i], vr[i], vl[i]);
            wait_idle();
        end

        // Back-pressure: result held, new requests ignored while in DONE
        out_ready = 1'b0;
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);
        for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
        a = 32'h40400000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result",    result,             32'h40000000);
            chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready",  {31'd0, in_ready},  32'd1);
        chk("release_result",    result,             32'h40000000);

        // Reset while normalising abandons the operation
        a = 32'h3F800001; b = 32'h3F800000; op = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("norm_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy",      {31'd0, busy},      32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rst_result",    result,             32'd0);
        repeat (30) @(negedge clk);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
